// File: rtl/adder_arbiter.sv
// Round-robin arbiter time-sharing one 8-bit + 4-bit adder among NREQ requesters.
// Optional macro ADDER_ARBITER_SAT_EN saturates the sum to 8'hFF on carry-out.
module adder_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_a,
    input  logic [4*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [7:0]          res_sum,
    output logic                res_co,
    output logic [IDW-1:0]      res_id
);

    localparam int unsigned AW = 8;
    localparam int unsigned BW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] last_q, last_d;
    logic [IDW-1:0] id_q, id_d;
    logic [AW-1:0]  op_a_q, op_a_d;
    logic [BW-1:0]  op_b_q, op_b_d;
    logic           res_valid_q, res_valid_d;
    logic [AW-1:0]  res_sum_q, res_sum_d;
    logic           res_co_q, res_co_d;
    logic [IDW-1:0] res_id_q, res_id_d;

    logic [NREQ-1:0] grant_c;
    logic [IDW-1:0]  grant_idx_c;
    logic            grant_any_c;
    logic [AW-1:0]   grant_a_c;
    logic [BW-1:0]   grant_b_c;
    logic [31:0]     dist_c;
    logic [31:0]     best_dist_c;
    logic [AW:0]     add_c;
    logic [AW-1:0]   sum_c;

    // Pick the valid requester closest after last_q in rotation order.
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        grant_a_c   = '0;
        grant_b_c   = '0;
        dist_c      = '0;
        best_dist_c = NREQ;
        for (int i = 0; i < int'(NREQ); i++) begin
            dist_c = (32'(i) + NREQ - 32'd1 - 32'(last_q)) % NREQ;
            if (req_valid[i] && (dist_c < best_dist_c)) begin
                best_dist_c = dist_c;
                grant_c     = '0;
                grant_c[i]  = 1'b1;
                grant_idx_c = IDW'(i);
                grant_a_c   = req_a[AW*i +: AW];
                grant_b_c   = req_b[BW*i +: BW];
            end
        end
        grant_any_c = (best_dist_c < NREQ);
    end

    assign add_c = {1'b0, op_a_q} + (AW+1)'(op_b_q);

`ifdef ADDER_ARBITER_SAT_EN
    assign sum_c = add_c[AW] ? {AW{1'b1}} : add_c[AW-1:0];
`else
    assign sum_c = add_c[AW-1:0];
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_co_d    = res_co_q;
        res_id_d    = res_id_q;
        case (state_q)
            IDLE: begin
                if (grant_any_c) begin
                    op_a_d  = grant_a_c;
                    op_b_d  = grant_b_c;
                    id_d    = grant_idx_c;
                    last_d  = grant_idx_c;
                    state_d = CALC;
                end
            end
            CALC: begin
                res_sum_d   = sum_c;
                res_co_d    = add_c[AW];
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= IDW'(NREQ - 1);
            id_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_co_q    <= 1'b0;
            res_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_co_q    <= res_co_d;
            res_id_q    <= res_id_d;
        end
    end

    // Grant is only offered while the adder is free.
    assign req_ready = (state_q == IDLE) ? grant_c : '0;
    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_co    = res_co_q;
    assign res_id    = res_id_q;

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Time-shares one 8-bit + 4-bit adder (eightbitadder cell: S = A + B, B zero-extended, carry-out Co) among NREQ requesters.
- Round-robin arbitration, valid/ready handshake per requester.
- Operands and results are registered; the registered result goes to a single downstream consumer with a requester ID.
- Sits between the operand producers and the result sink in the arithmetic datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of requester ID; must be >= clog2(NREQ)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  NREQ  bit i: requester i presents operands
req_a  input  8*NREQ  8-bit operand A of requester i at [8i+7:8i]
req_b  input  4*NREQ  4-bit operand B of requester i at [4i+3:4i]
req_ready  output  NREQ  one-hot grant; requester i handshake when req_valid[i] & req_ready[i]
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_sum  output  8  registered sum S
res_co  output  1  registered carry-out
res_id  output  IDW  index of requester that owns the result

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE; req_ready=0; res_valid=0; res_sum=0; res_co=0; res_id=0.
  - Operand regs=0; round-robin pointer last=NREQ-1, so requester 0 has top priority.
- FSM states: IDLE, CALC, HOLD.
- IDLE:
  - req_ready is combinational: one-hot on the first i with req_valid[i]=1, searching last+1, last+2, ... mod NREQ.
  - req_ready=0 when no valid bit is set.
  - At most one req_ready bit is set, and only in IDLE.
  - On a grant edge: capture req_a[i]/req_b[i] into operand regs, id_reg=i, last=i, go to CALC.
  - Stay in IDLE if nothing is valid.
- CALC (1 cycle):
  - req_ready=0.
  - Adder sees the operand regs; at the edge, res_sum=S, res_co=Co, res_id=id_reg, res_valid=1; go to HOLD.
- HOLD:
  - res_valid=1; res_sum/res_co/res_id stay stable until handshake.
  - On res_valid & res_ready: res_valid=0 at the next edge, go to IDLE.
  - req_ready=0 throughout HOLD.
- Latency and throughput:
  - Grant edge at cycle N; res_valid=1 from cycle N+2.
  - Minimum 3 cycles per transaction (grant, calc, hold+accept). res_ready held high gives one result per 3 cycles.
- Arithmetic:
  - res_sum = (A + {4'b0,B}) mod 256.
  - res_co = 1 iff A + B > 255.
  - Only possible with A >= 0xF1 and B large enough, e.g. 0xFF+0xF = 0x10E, giving sum 0x0E, co 1.
- Fairness: the requester granted last has lowest priority next arbitration. Continuously valid requesters are served in strict rotation, so no starvation.
- Requesters must hold req_valid/operands until their handshake. Dropping req_valid before grant is legal; no transaction occurs.
- Requester valid during CALC/HOLD waits; it is arbitrated in the next IDLE cycle.
- Reset mid-operation (CALC or HOLD): in-flight transaction is discarded with no result delivered; all state returns to reset values.
- A res_ready=1 while res_valid=0 is ignored.
- Requester indices >= NREQ are never granted; unused res_id codes never appear.

Optional Feature:
- Macro: ADDER_ARBITER_SAT_EN.
- Defined: in CALC, if Co=1 then res_sum=8'hFF (saturated); res_co still reports the raw carry (1). No effect when Co=0.
- Undefined: res_sum is the wrapped modulo-256 sum; no saturation logic is generated.

Test Plan:
1. Reset, then req_valid=4'b0001, A0=0x12, B0=0x3 -> req_ready=0001 in cycle 1; res_valid at cycle 3 with sum 0x15, co 0, id 0; res_ready=1 returns FSM to IDLE.
2. All four valid continuously, res_ready=1 -> grant order 0,1,2,3,0,...; res_id sequence 0,1,2,3,0, one result every 3 cycles.
3. A=0xFF, B=0xF -> sum 0x0E, co 1; with ADDER_ARBITER_SAT_EN -> sum 0xFF, co 1.
4. res_ready=0 for 5 cycles in HOLD while requester 2 is valid -> res_* stable, req_ready stays 0000. Raising res_ready then grants requester 2 in the following IDLE cycle.
5. Assert rst during CALC -> next cycle res_valid=0, res_sum=0, req_ready=0. With req_valid=1010 after reset, requester 1 is granted first.
6. Only requester 3 valid after requester 3 was just served -> granted again, since rotation skips idle requesters.
